// File: rtl/mips_codes.sv
// MIPS instruction field encodings that the multicycle controller decodes.
package mips_codes;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_JR    = 6'b001000;

endpackage

// File: rtl/mips_ctrl_pkg.sv
// Shared types for the multicycle MIPS controller: state encoding, ALU op
// codes, datapath mux selects and the per-state control word.
// MIPS_CTRL_ILLEGAL_TRAP_EN adds the TRAP state.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH,
      DECODE,
      MEM_ADDR,
      MEM_RD,
      MEM_WB,
      MEM_WR,
      R_EXEC,
      R_WB,
      BRANCH,
      JUMP_REG,
      ADDI_EXEC,
      ADDI_WB,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      JAL,
      TRAP
`else
      JAL
`endif
   } ctrl_state_t;

   localparam logic [2:0] ALU_ADD   = 3'b010;
   localparam logic [2:0] ALU_SUB   = 3'b110;
   localparam logic [2:0] ALU_FUNCT = 3'b111;

   localparam logic       IORD_PC     = 1'b0;
   localparam logic       IORD_ALUOUT = 1'b1;

   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   localparam logic [1:0] M2R_ALUOUT = 2'b00;
   localparam logic [1:0] M2R_MDR    = 2'b01;
   localparam logic [1:0] M2R_PC     = 2'b10;

   localparam logic       SRCA_PC = 1'b0;
   localparam logic       SRCA_A  = 1'b1;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] reg_dst;
      logic [1:0] mem2reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [2:0] alu_op;
      logic [1:0] pc_source;
      logic       sign_xtend;
      logic       instr_done;
   } ctrl_word_t;

endpackage

// File: rtl/mips_mc_ctrl_decode.sv
// State-to-control-word decode for the multicycle controller (combinational).
module mips_mc_ctrl_decode
   import mips_ctrl_pkg::*;
(
   input  ctrl_state_t state,
   input  logic        funct0,
   output ctrl_word_t  word
);

   // Every field defaults to 0; each state raises only its own controls.
   always_comb begin
      word = '0;
      case (state)
         FETCH: begin
            word.mem_read  = 1'b1;
            word.ir_write  = 1'b1;
            word.alu_src_a = SRCA_PC;
            word.alu_src_b = SRCB_FOUR;
            word.alu_op    = ALU_ADD;
            word.pc_source = PCSRC_ALU;
            word.pc_write  = 1'b1;
         end
         DECODE: begin
            word.alu_src_a = SRCA_PC;
            word.alu_src_b = SRCB_IMM_SH;
            word.alu_op    = ALU_ADD;
         end
         MEM_ADDR, ADDI_EXEC: begin
            word.alu_src_a  = SRCA_A;
            word.alu_src_b  = SRCB_IMM;
            word.alu_op     = ALU_ADD;
            word.sign_xtend = 1'b1;
         end
         MEM_RD: begin
            word.mem_read = 1'b1;
            word.i_or_d   = IORD_ALUOUT;
         end
         MEM_WB: begin
            word.reg_write  = 1'b1;
            word.reg_dst    = REGDST_RT;
            word.mem2reg    = M2R_MDR;
            word.instr_done = 1'b1;
         end
         MEM_WR: begin
            // instr_done is qualified by mem_ready in the top level
            word.mem_write  = 1'b1;
            word.i_or_d     = IORD_ALUOUT;
            word.instr_done = 1'b1;
         end
         R_EXEC: begin
            // odd funct codes (addu/subu style) work on unsigned operands
            word.alu_src_a  = SRCA_A;
            word.alu_src_b  = SRCB_B;
            word.alu_op     = ALU_FUNCT;
            word.sign_xtend = ~funct0;
         end
         R_WB: begin
            word.reg_write  = 1'b1;
            word.reg_dst    = REGDST_RD;
            word.mem2reg    = M2R_ALUOUT;
            word.instr_done = 1'b1;
         end
         ADDI_WB: begin
            word.reg_write  = 1'b1;
            word.reg_dst    = REGDST_RT;
            word.mem2reg    = M2R_ALUOUT;
            word.instr_done = 1'b1;
         end
         BRANCH: begin
            word.alu_src_a     = SRCA_A;
            word.alu_src_b     = SRCB_B;
            word.alu_op        = ALU_SUB;
            word.pc_write_cond = 1'b1;
            word.pc_source     = PCSRC_ALUOUT;
            word.instr_done    = 1'b1;
         end
         JAL: begin
            word.pc_write   = 1'b1;
            word.pc_source  = PCSRC_JUMP;
            word.reg_write  = 1'b1;
            word.reg_dst    = REGDST_RA;
            word.mem2reg    = M2R_PC;
            word.instr_done = 1'b1;
         end
         JUMP_REG: begin
            word.pc_write   = 1'b1;
            word.pc_source  = PCSRC_REG;
            word.instr_done = 1'b1;
         end
         default: word = '0;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: state register, next-state logic and output
// qualification. Define MIPS_CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes
// in a sticky TRAP state with an illegal_op flag; otherwise they act as NOPs.
module mips_mc_ctrl
   import mips_ctrl_pkg::*;
   import mips_codes::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_en,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem2reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_source,
   output logic       sign_xtend,
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   output logic       illegal_op,
`endif
   output logic       instr_done
);

   ctrl_state_t state_q, state_d;
   ctrl_word_t  word;
   logic        is_illegal;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   logic        illegal_q, illegal_d;
`endif

   mips_mc_ctrl_decode u_decode (
      .state  (state_q),
      .funct0 (funct[0]),
      .word   (word)
   );

   // State register (and sticky trap flag) with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= FETCH;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         illegal_q <= illegal_d;
`endif
      end
   end

   // Opcode classification and next-state selection
   always_comb begin
      is_illegal = 1'b0;
      state_d    = state_q;
      case (opcode)
         OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BNE, OP_JAL: is_illegal = 1'b0;
         default:                                         is_illegal = 1'b1;
      endcase
      case (state_q)
         FETCH:    if (mem_ready) state_d = DECODE;
         DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = MEM_ADDR;
               OP_RTYPE:     state_d = (funct == FN_JR) ? JUMP_REG : R_EXEC;
               OP_ADDI:      state_d = ADDI_EXEC;
               OP_BNE:       state_d = BRANCH;
               OP_JAL:       state_d = JAL;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
               default:      state_d = TRAP;
`else
               default:      state_d = FETCH;
`endif
            endcase
         end
         MEM_ADDR:  state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
         MEM_RD:    if (mem_ready) state_d = MEM_WB;
         MEM_WR:    if (mem_ready) state_d = FETCH;
         R_EXEC:    state_d = R_WB;
         ADDI_EXEC: state_d = ADDI_WB;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         TRAP:      state_d = TRAP;
`endif
         default:   state_d = FETCH;
      endcase
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      illegal_d = illegal_q | (state_d == TRAP);
`endif
   end

   // Output qualification: memory handshakes gate PC write and completion,
   // and everything is forced quiet while reset is held.
   always_comb begin
      logic pc_write_q;
      logic done;
      pc_write_q = word.pc_write;
      if (state_q == FETCH) pc_write_q = word.pc_write & mem_ready;
      done = word.instr_done;
      if (state_q == MEM_WR) done = word.instr_done & mem_ready;
`ifndef MIPS_CTRL_ILLEGAL_TRAP_EN
      if ((state_q == DECODE) && is_illegal) done = 1'b1;
`endif
      pc_en      = rst_n & (pc_write_q | (word.pc_write_cond & ~zero));
      i_or_d     = rst_n & word.i_or_d;
      mem_read   = rst_n & word.mem_read;
      mem_write  = rst_n & word.mem_write;
      ir_write   = rst_n & word.ir_write;
      reg_write  = rst_n & word.reg_write;
      reg_dst    = rst_n ? word.reg_dst : 2'b00;
      mem2reg    = rst_n ? word.mem2reg : 2'b00;
      alu_src_a  = rst_n & word.alu_src_a;
      alu_src_b  = rst_n ? word.alu_src_b : 2'b00;
      alu_op     = rst_n ? word.alu_op : 3'b000;
      pc_source  = rst_n ? word.pc_source : 2'b00;
      sign_xtend = rst_n & word.sign_xtend;
      instr_done = rst_n & done;
   end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed scoreboard bench for mips_mc_ctrl: each driven cycle pushes its
// hand-derived control vector; a negedge monitor pops and compares.
module tb_mips_mc_ctrl;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write;
   logic [1:0] reg_dst, mem2reg, alu_src_b, pc_source;
   logic       alu_src_a, sign_xtend, instr_done;
   logic [2:0] alu_op;
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   mips_mc_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_en      (pc_en),
      .i_or_d     (i_or_d),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem2reg    (mem2reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_source  (pc_source),
      .sign_xtend (sign_xtend),
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      .illegal_op (illegal_op),
`endif
      .instr_done (instr_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      name;
      logic [19:0] vec;
      logic       il;
      bit         chk_il;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Field order: pc_en i_or_d mem_read mem_write ir_write reg_write reg_dst
   // mem2reg alu_src_a alu_src_b alu_op pc_source sign_xtend instr_done
   function automatic logic [19:0] mk(input logic pe, input logic iod,
      input logic mr, input logic mw, input logic irw, input logic rw,
      input logic [1:0] rd, input logic [1:0] m2r, input logic sa,
      input logic [1:0] sb, input logic [2:0] op, input logic [1:0] ps,
      input logic sx, input logic dn);
      return {pe, iod, mr, mw, irw, rw, rd, m2r, sa, sb, op, ps, sx, dn};
   endfunction

   // Monitor: every cycle that has an expectation queued is compared
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [19:0] act;
         e = q.pop_front();
         act = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_write,
                reg_dst, mem2reg, alu_src_a, alu_src_b, alu_op, pc_source,
                sign_xtend, instr_done};
         checks++;
         if (act !== e.vec) begin
            errors++;
            $display("FAIL %s: ctrl got %b expected %b", e.name, act, e.vec);
         end else begin
            $display("ok   %s: ctrl %b", e.name, act);
         end
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
         if (e.chk_il) begin
            checks++;
            if (illegal_op !== e.il) begin
               errors++;
               $display("FAIL %s: illegal_op got %b expected %b", e.name, illegal_op, e.il);
            end
         end
`endif
      end
   end

   task automatic cyc(input string name, input logic rst, input logic [5:0] opc,
                      input logic [5:0] fn, input logic z, input logic rdy,
                      input logic [19:0] vec, input logic il, input bit chk_il);
      exp_t e;
      rst_n = rst; opcode = opc; funct = fn; zero = z; mem_ready = rdy;
      e.name = name; e.vec = vec; e.il = il; e.chk_il = chk_il;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] ADDI = 6'b001000, BNE = 6'b000101, JALOP = 6'b000011;
   localparam logic [5:0] BAD = 6'b111111;

   logic [19:0] v_zero, v_fetch, v_fetch_w, v_dec, v_addr, v_rd, v_wb;
   logic [19:0] v_wr, v_wr_w, v_rex, v_rex_u, v_rwb, v_awb, v_bt, v_bnt;
   logic [19:0] v_jal, v_jr, v_dec_ill;

   initial begin
      v_zero    = '0;
      v_fetch   = mk(1,0,1,0,1,0,2'b00,2'b00,0,2'b01,3'b010,2'b00,0,0);
      v_fetch_w = mk(0,0,1,0,1,0,2'b00,2'b00,0,2'b01,3'b010,2'b00,0,0);
      v_dec     = mk(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b010,2'b00,0,0);
      v_dec_ill = mk(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b010,2'b00,0,1);
      v_addr    = mk(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b010,2'b00,1,0);
      v_rd      = mk(0,1,1,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0,0);
      v_wb      = mk(0,0,0,0,0,1,2'b00,2'b01,0,2'b00,3'b000,2'b00,0,1);
      v_wr      = mk(0,1,0,1,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0,1);
      v_wr_w    = mk(0,1,0,1,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0,0);
      v_rex     = mk(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b111,2'b00,1,0);
      v_rex_u   = mk(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b111,2'b00,0,0);
      v_rwb     = mk(0,0,0,0,0,1,2'b01,2'b00,0,2'b00,3'b000,2'b00,0,1);
      v_awb     = mk(0,0,0,0,0,1,2'b00,2'b00,0,2'b00,3'b000,2'b00,0,1);
      v_bt      = mk(1,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b110,2'b01,0,1);
      v_bnt     = mk(0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b110,2'b01,0,1);
      v_jal     = mk(1,0,0,0,0,1,2'b10,2'b10,0,2'b00,3'b000,2'b10,0,1);
      v_jr      = mk(1,0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b11,0,1);

      rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc("reset c1", 0, LW, 6'd0, 0, 1, v_zero, 0, 1);
      cyc("reset c2", 0, LW, 6'd0, 0, 1, v_zero, 0, 1);
      // LW, no stalls: 5 cycles
      cyc("lw fetch",  1, LW, 6'd0, 0, 1, v_fetch, 0, 1);
      cyc("lw decode", 1, LW, 6'd0, 0, 1, v_dec,   0, 0);
      cyc("lw addr",   1, LW, 6'd0, 0, 1, v_addr,  0, 0);
      cyc("lw memrd",  1, LW, 6'd0, 0, 1, v_rd,    0, 0);
      cyc("lw wb",     1, LW, 6'd0, 0, 1, v_wb,    0, 0);
      // SW with 3 wait cycles in MEM_WR: 7 cycles
      cyc("sw fetch",  1, SW, 6'd0, 0, 1, v_fetch, 0, 0);
      cyc("sw decode", 1, SW, 6'd0, 0, 1, v_dec,   0, 0);
      cyc("sw addr",   1, SW, 6'd0, 0, 1, v_addr,  0, 0);
      cyc("sw wait1",  1, SW, 6'd0, 0, 0, v_wr_w,  0, 0);
      cyc("sw wait2",  1, SW, 6'd0, 0, 0, v_wr_w,  0, 0);
      cyc("sw wait3",  1, SW, 6'd0, 0, 0, v_wr_w,  0, 0);
      cyc("sw done",   1, SW, 6'd0, 0, 1, v_wr,    0, 0);
      // R-type add (signed) with a stalled fetch
      cyc("add fetchw", 1, RT, 6'b100000, 0, 0, v_fetch_w, 0, 0);
      cyc("add fetch",  1, RT, 6'b100000, 0, 1, v_fetch,   0, 0);
      cyc("add decode", 1, RT, 6'b100000, 0, 1, v_dec,     0, 0);
      cyc("add exec",   1, RT, 6'b100000, 0, 1, v_rex,     0, 0);
      cyc("add wb",     1, RT, 6'b100000, 0, 1, v_rwb,     0, 0);
      // R-type addu (unsigned)
      cyc("addu fetch",  1, RT, 6'b100001, 0, 1, v_fetch, 0, 0);
      cyc("addu decode", 1, RT, 6'b100001, 0, 1, v_dec,   0, 0);
      cyc("addu exec",   1, RT, 6'b100001, 0, 1, v_rex_u, 0, 0);
      cyc("addu wb",     1, RT, 6'b100001, 0, 1, v_rwb,   0, 0);
      // ADDI
      cyc("addi fetch",  1, ADDI, 6'd0, 0, 1, v_fetch, 0, 0);
      cyc("addi decode", 1, ADDI, 6'd0, 0, 1, v_dec,   0, 0);
      cyc("addi exec",   1, ADDI, 6'd0, 0, 1, v_addr,  0, 0);
      cyc("addi wb",     1, ADDI, 6'd0, 0, 1, v_awb,   0, 0);
      // BNE not taken (zero=1) then taken (zero=0)
      cyc("bne1 fetch",  1, BNE, 6'd0, 1, 1, v_fetch, 0, 0);
      cyc("bne1 decode", 1, BNE, 6'd0, 1, 1, v_dec,   0, 0);
      cyc("bne1 branch", 1, BNE, 6'd0, 1, 1, v_bnt,   0, 0);
      cyc("bne0 fetch",  1, BNE, 6'd0, 0, 1, v_fetch, 0, 0);
      cyc("bne0 decode", 1, BNE, 6'd0, 0, 1, v_dec,   0, 0);
      cyc("bne0 branch", 1, BNE, 6'd0, 0, 1, v_bt,    0, 0);
      // JAL and JR
      cyc("jal fetch",  1, JALOP, 6'd0, 0, 1, v_fetch, 0, 0);
      cyc("jal decode", 1, JALOP, 6'd0, 0, 1, v_dec,   0, 0);
      cyc("jal jump",   1, JALOP, 6'd0, 0, 1, v_jal,   0, 0);
      cyc("jr fetch",   1, RT, 6'b001000, 0, 1, v_fetch, 0, 0);
      cyc("jr decode",  1, RT, 6'b001000, 0, 1, v_dec,   0, 0);
      cyc("jr jump",    1, RT, 6'b001000, 0, 1, v_jr,    0, 0);
      // Reset in the middle of a LW abandons it
      cyc("lwr fetch",  1, LW, 6'd0, 0, 1, v_fetch, 0, 0);
      cyc("lwr decode", 1, LW, 6'd0, 0, 1, v_dec,   0, 0);
      cyc("lwr addr",   1, LW, 6'd0, 0, 1, v_addr,  0, 0);
      cyc("lwr reset",  0, LW, 6'd0, 0, 1, v_zero,  0, 0);
      cyc("lwr refetch",1, LW, 6'd0, 0, 1, v_fetch, 0, 0);
      cyc("lwr decode2",1, LW, 6'd0, 0, 1, v_dec,   0, 0);
      cyc("lwr addr2",  1, LW, 6'd0, 0, 1, v_addr,  0, 0);
      cyc("lwr memrd",  1, LW, 6'd0, 0, 1, v_rd,    0, 0);
      cyc("lwr wb",     1, LW, 6'd0, 0, 1, v_wb,    0, 0);
      // Illegal opcode
      cyc("ill fetch", 1, BAD, 6'd0, 0, 1, v_fetch, 0, 1);
`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
      cyc("ill decode", 1, BAD, 6'd0, 0, 1, v_dec, 0, 1);
      for (int i = 0; i < 10; i++) cyc("ill trap", 1, LW, 6'd0, 0, 1, v_zero, 1, 1);
      cyc("ill reset",   0, LW, 6'd0, 0, 1, v_zero,  0, 0);
      cyc("ill refetch", 1, LW, 6'd0, 0, 1, v_fetch, 0, 1);
`else
      cyc("ill decode",  1, BAD, 6'd0, 0, 1, v_dec_ill, 0, 0);
      cyc("ill refetch", 1, LW,  6'd0, 0, 1, v_fetch,   0, 0);
      cyc("ill decode2", 1, LW,  6'd0, 0, 1, v_dec,     0, 0);
`endif

      begin
         int n;
         n = 0;
         while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
         end
         #1;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
